// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file writeback controller.
package rf_pkg;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MC  = 1'b1
  } src_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; req/gnt bit 0 is the ALU, bit 1 is the MC unit.
module rr_arb2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  src_e last_q, last_d;

  // A grant is always a transfer, because ready is only asserted toward a valid source.
  always_comb begin
    gnt_o  = req_i;
    last_d = last_q;
    if (req_i == 2'b11) gnt_o = (last_q == SRC_MC) ? 2'b01 : 2'b10;
    if (gnt_o[0])      last_d = SRC_ALU;
    else if (gnt_o[1]) last_d = SRC_MC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= SRC_MC;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/rf_wb_ctrl.sv
// RF writeback controller: arbitrates ALU/MC results onto the single write port,
// tracks outstanding MC destinations and flags decode read hazards.
module rf_wb_ctrl
  import rf_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [ADDR_W-1:0]   alu_addr,
  input  logic [DATA_W-1:0]   alu_data,
  input  logic                mc_valid,
  output logic                mc_ready,
  input  logic [ADDR_W-1:0]   mc_addr,
  input  logic [DATA_W-1:0]   mc_data,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_addr,
  input  logic [ADDR_W-1:0]   RsAddr,
  input  logic [ADDR_W-1:0]   RtAddr,
  output logic                stall,
  output logic [ADDR_W-1:0]   RdAddr,
  output logic [DATA_W-1:0]   RdData,
  output logic                RegWrite,
  output logic [NUM_REGS-1:0] busy
);

  logic [1:0]          gnt;
  logic                alu_xfer, mc_xfer;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                we_q, we_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i ({mc_valid, alu_valid}),
    .gnt_o (gnt)
  );

  assign alu_ready = gnt[0];
  assign mc_ready  = gnt[1];
  assign alu_xfer  = alu_valid & alu_ready;
  assign mc_xfer   = mc_valid & mc_ready;

  always_comb begin
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    we_d      = 1'b0;
    if (alu_xfer) begin
      rd_addr_d = alu_addr;
      rd_data_d = alu_data;
      we_d      = (alu_addr != '0);
    end else if (mc_xfer) begin
      rd_addr_d = mc_addr;
      rd_data_d = mc_data;
      we_d      = (mc_addr != '0);
    end
  end

  // Set is applied after clear so a re-issue to the retiring address stays busy.
  always_comb begin
    busy_d = busy_q;
    if (mc_xfer)     busy_d[mc_addr]    = 1'b0;
    if (issue_valid) busy_d[issue_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q <= '0;
      rd_data_q <= '0;
      we_q      <= 1'b0;
      busy_q    <= '0;
    end else begin
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
    end
  end

  assign RdAddr   = rd_addr_q;
  assign RdData   = rd_data_q;
  assign RegWrite = we_q;
  assign busy     = busy_q;

  // The RF write lands in the low phase, so a same-cycle read would see the stale value.
  function automatic logic hazard(input logic [ADDR_W-1:0] a,
                                  input logic [NUM_REGS-1:0] bz,
                                  input logic we, input logic [ADDR_W-1:0] wa);
    return (a != '0) && (bz[a] || (we && (wa == a)));
  endfunction

  assign stall = hazard(RsAddr, busy_q, we_q, rd_addr_q) |
                 hazard(RtAddr, busy_q, we_q, rd_addr_q);

  a_alu_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
    !(alu_xfer && (alu_addr != '0) && busy_q[alu_addr]));

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Randomized + directed bench for rf_wb_ctrl with a queue-based scoreboard.
module tb_rf_wb_ctrl;
  import rf_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic alu_valid, alu_ready, mc_valid, mc_ready, issue_valid, stall, RegWrite;
  logic [4:0]  alu_addr, mc_addr, issue_addr, RsAddr, RtAddr, RdAddr;
  logic [31:0] alu_data, mc_data, RdData, busy;

  rf_wb_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_addr(mc_addr), .mc_data(mc_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .RsAddr(RsAddr), .RtAddr(RtAddr), .stall(stall),
    .RdAddr(RdAddr), .RdData(RdData), .RegWrite(RegWrite), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] bz;
  } exp_t;
  exp_t q[$];

  int n_tests = 0, n_fail = 0;

  // Reference model state
  logic [31:0] mbusy;
  bit          mlast_mc;
  logic        mwe;
  logic [4:0]  mrd;
  logic [31:0] mdat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mbusy = '0; mlast_mc = 1'b1; mwe = 1'b0; mrd = '0; mdat = '0;
  endtask

  function automatic bit m_hz(input logic [4:0] a);
    return (a != 0) && (mbusy[a] || (mwe && mrd == a));
  endfunction

  // One clock of stimulus: drive, check combinational outputs, advance model, queue expectation.
  task automatic cycle(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic iv, input logic [4:0] ia,
                       input logic [4:0] rs, input logic [4:0] rt,
                       output logic ga, output logic gm);
    bit ea, em;
    @(negedge clk); #1;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mc_valid = mv; mc_addr = ma; mc_data = md;
    issue_valid = iv; issue_addr = ia; RsAddr = rs; RtAddr = rt;
    #1;
    ea = av && (!mv || mlast_mc);
    em = mv && (!av || !mlast_mc);
    ga = alu_ready; gm = mc_ready;
    chk("alu_ready", 64'(alu_ready), 64'(ea));
    chk("mc_ready", 64'(mc_ready), 64'(em));
    chk("stall", 64'(stall), 64'(m_hz(rs) || m_hz(rt)));
    if (ea) begin mwe = (aa != 0); mrd = aa; mdat = ad; mlast_mc = 1'b0; end
    else if (em) begin mwe = (ma != 0); mrd = ma; mdat = md; mlast_mc = 1'b1; end
    else mwe = 1'b0;
    if (em) mbusy[ma] = 1'b0;
    if (iv && ia != 0) mbusy[ia] = 1'b1;
    q.push_back('{we: mwe, a: mrd, d: mdat, bz: mbusy});
  endtask

  task automatic idle(input logic [4:0] rs, input logic [4:0] rt);
    logic ga, gm;
    cycle(0, 0, 0, 0, 0, 0, 0, 0, rs, rt, ga, gm);
  endtask

  // Monitor: one expectation per registered output update.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("RegWrite", 64'(RegWrite), 64'(e.we));
        chk("RdAddr", 64'(RdAddr), 64'(e.a));
        chk("RdData", 64'(RdData), 64'(e.d));
        chk("busy", 64'(busy), 64'(e.bz));
      end else begin
        chk("idle_RegWrite", 64'(RegWrite), 64'(0));
      end
    end
  end

  initial begin
    logic ga, gm;
    bit pa, pm;
    logic [4:0] ra, rm, ri;
    logic [31:0] da, dm;

    rst_n = 1'b0;
    alu_valid = 0; alu_addr = 0; alu_data = 0; mc_valid = 0; mc_addr = 0; mc_data = 0;
    issue_valid = 0; issue_addr = 0; RsAddr = 0; RtAddr = 0;
    model_reset();
    #11;
    chk("rst_RegWrite", 64'(RegWrite), 64'(0));
    chk("rst_RdAddr", 64'(RdAddr), 64'(0));
    chk("rst_RdData", 64'(RdData), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    #1 rst_n = 1'b1;

    // Contention: ALU first after reset, then strict alternation
    for (int k = 0; k < 4; k++) begin
      cycle(1, 5'd1, 32'hA0 + k, 1, 5'd2, 32'hB0 + k, 0, 0, 0, 0, ga, gm);
      chk("cont_grant", 64'({ga, gm}), (k % 2 == 0) ? 64'b10 : 64'b01);
    end

    // Single ALU write and its one-cycle forwarding hazard
    cycle(1, 5'd3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, ga, gm);
    chk("alu_single_ready", 64'(ga), 64'(1));
    idle(5'd3, 0);
    idle(5'd3, 0);

    // Scoreboard on register 7
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 0, ga, gm);
    idle(0, 5'd7);
    idle(0, 5'd7);
    cycle(0, 0, 0, 1, 5'd7, 32'h77, 0, 0, 0, 5'd7, ga, gm);
    idle(0, 5'd7);
    idle(0, 5'd7);

    // Set/clear collision on register 9
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 0, ga, gm);
    cycle(0, 0, 0, 1, 5'd9, 32'h99, 1, 5'd9, 0, 0, ga, gm);
    idle(5'd9, 0);
    chk("collision_busy9", 64'(busy[9]), 64'(1));

    // Zero register: acknowledged but not written, never busy
    cycle(1, 5'd0, 32'h1234, 0, 0, 0, 1, 5'd0, 0, 0, ga, gm);
    chk("zero_ready", 64'(ga), 64'(1));
    idle(0, 0);

    // Asynchronous reset mid-operation with busy[5] and a write pending
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd5, 0, 0, ga, gm);
    cycle(1, 5'd4, 32'h4444, 0, 0, 0, 0, 0, 5'd5, 5'd4, ga, gm);
    @(posedge clk); #2;
    chk("pre_rst_RegWrite", 64'(RegWrite), 64'(1));
    chk("pre_rst_busy5", 64'(busy[5]), 64'(1));
    alu_valid = 0; mc_valid = 0; issue_valid = 0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_RegWrite", 64'(RegWrite), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_stall", 64'(stall), 64'(0));
    q.delete();
    model_reset();
    @(negedge clk); #2 rst_n = 1'b1;

    // Randomized traffic; ALU uses 0..15 and MC/issue uses 16..31 so ALU never hits a busy reg
    pa = 0; pm = 0; ra = 0; rm = 0; da = 0; dm = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!pa && ($urandom_range(0, 2) != 0)) begin
        pa = 1; ra = 5'($urandom_range(0, 15)); da = $urandom;
      end
      if (!pm && ($urandom_range(0, 2) != 0)) begin
        pm = 1; rm = 5'($urandom_range(16, 31)); dm = $urandom;
      end
      ri = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(16, 31));
      cycle(pa, ra, da, pm, rm, dm, ($urandom_range(0, 3) == 0), ri,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), ga, gm);
      if (ga) pa = 0;
      if (gm) pm = 0;
    end
    idle(0, 0);
    idle(0, 0);
    @(negedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_ctrl.md
# rf_wb_ctrl

Writeback controller for the 32x32 register file (RF). It shares the single RF write port between two writeback sources, the single-cycle ALU path and the multi-cycle unit (MC: multiply/divide/load), using round-robin arbitration with valid/ready handshakes. It keeps a busy scoreboard of destinations with an MC result still outstanding, and raises a read-hazard stall for the decode stage.

## Interface
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- NUM_REGS, 32, scoreboard entries (2**ADDR_W)
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request granted this cycle
- alu_addr  in  ADDR_W  ALU destination
- alu_data  in  DATA_W  ALU result
- mc_valid  in  1  MC writeback request
- mc_ready  out  1  MC request granted this cycle
- mc_addr  in  ADDR_W  MC destination
- mc_data  in  DATA_W  MC result
- issue_valid  in  1  MC op issued this cycle; mark destination busy
- issue_addr  in  ADDR_W  destination of issued MC op
- RsAddr  in  ADDR_W  decode-stage source 1
- RtAddr  in  ADDR_W  decode-stage source 2
- stall  out  1  decode must hold (read hazard)
- RdAddr  out  ADDR_W  RF write address (registered)
- RdData  out  DATA_W  RF write data (registered)
- RegWrite  out  1  RF write enable (registered)
- busy  out  NUM_REGS  scoreboard vector (debug/verification)

## Operation
- Transfer on a source = valid && ready at a posedge. Ready is combinational from valid inputs and the last_grant state.
- Arbitration:
  - one valid source: that source is granted;
  - both valid: the source not granted last is granted;
  - last_grant updates only on a transfer.
- Ready does not depend on the source's own data. A granted source must hold valid/addr/data stable until its transfer.
- On transfer: RdAddr and RdData load from the granted source. RegWrite = 1 if addr != 0, else 0 (the write is dropped but still acknowledged).
- No transfer in a cycle: RegWrite = 0; RdAddr and RdData hold their values.
- Scoreboard:
  - issue_valid sets busy[issue_addr];
  - an MC transfer clears busy[mc_addr];
  - busy[0] is never set;
  - same address set and cleared in the same cycle: set wins (the new op is outstanding).
- ALU transfers never touch the scoreboard.
- Upstream guarantees no ALU write to an address that is busy. This is checked by an assertion, not handled in logic.
- stall (combinational) = 1 when either holds for RsAddr or RtAddr (address 0 excluded):
  - busy[addr] = 1;
  - addr == RdAddr while RegWrite = 1 (the write lands in the low phase, so decode must not use the pre-write value).
- Reset (asynchronous, rst_n = 0):
  - RegWrite = 0, RdAddr = 0, RdData = 0;
  - busy = all 0;
  - last_grant = MC, so the ALU wins the first tie;
  - stall follows combinationally from the cleared state.
- Reset mid-operation discards every in-flight grant and scoreboard entry.

## Timing
- Cycle N: valid && ready. Cycle N+1: RegWrite, RdAddr and RdData are valid from the posedge. The RF captures during the clk-low phase of N+1.
- Latency: 1 cycle from request to write-port drive. Throughput: 1 write per cycle.
- Under continuous contention, grants alternate ALU, MC, ALU, ... Maximum wait for a valid source is 1 cycle.
- busy[x] changes at the posedge after issue/transfer. stall reflects the new value in that same following cycle.
- Outputs are glitch-free relative to the posedge (registered). ready and stall are combinational and must settle within the high phase.

## Structure
- Shared package rf_pkg:
  - ADDR_W, DATA_W, NUM_REGS constants;
  - src_e enum {SRC_ALU, SRC_MC} used for last_grant.
- Sub-module rr_arb2: 2-input round-robin arbiter with last-grant register, outputs a one-hot grant.
- Scoreboard, output registers and hazard compare stay in rf_wb_ctrl.

## Test plan
- Reset: assert rst_n = 0 mid-cycle with busy[5] = 1 and RegWrite = 1 -> immediately RegWrite = 0, busy = 0, stall = 0.
- Single ALU write:
  - stimulus: alu_valid, addr 3, data 0xDEADBEEF;
  - response: alu_ready the same cycle; next cycle RegWrite = 1, RdAddr = 3, RdData = 0xDEADBEEF; RsAddr = 3 gives stall = 1 for that cycle only.
- Contention: both sources valid for 4 cycles (ALU addr 1, MC addr 2) -> grants ALU, MC, ALU, MC; RegWrite high for 4 consecutive cycles.
- Scoreboard:
  - stimulus: issue_valid with addr 7, then RtAddr = 7;
  - response: stall = 1 until the cycle after the MC transfer with mc_addr = 7, then stall = 0 (unless RegWrite targets 7).
- Set/clear collision: MC transfer with addr 9 and issue_valid with addr 9 in the same cycle -> busy[9] stays 1.
- Zero register: ALU transfer with addr 0, data 0x1234 -> alu_ready = 1, RegWrite = 0 next cycle; issue_valid with addr 0 leaves busy = 0.
